// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y - bin, LSB first, with start/done handshake.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;
    logic             a, b, d, bn;
`ifdef SERIAL_SUB_OVF_EN
    logic             xm_q, xm_d, ym_q, ym_d, ovf_q, ovf_d;
`endif

    assign a  = xs_q[0];
    assign b  = ys_q[0];
    assign d  = a ^ b ^ br_q;
    assign bn = (~a & b) | (~a & br_q) | (b & br_q);

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        br_d    = br_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        xm_d    = xm_q;
        ym_d    = ym_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                xs_d    = x;
                ys_d    = y;
                br_d    = bin;
                res_d   = '0;
                cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                xm_d    = x[WIDTH-1];
                ym_d    = y[WIDTH-1];
`endif
            end
            RUN: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                br_d  = bn;
                res_d = {d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {d, res_q[WIDTH-1:1]};
                    bout_d  = bn;
`ifdef SERIAL_SUB_OVF_EN
                    // d is the result MSB on the final step
                    ovf_d   = (xm_q != ym_q) && (d != xm_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            xm_q    <= 1'b0;
            ym_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0, y = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n = 0, fails = 0;
    int prev_diff = 0, prev_bout = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_diff(input int xv, input int yv, input int bv);
        return (xv - yv - bv) & ((1 << W) - 1);
    endfunction

    function automatic int ref_bout(input int xv, input int yv, input int bv);
        return (xv < yv + bv) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int xv, input int yv, input int bv);
        int h = 1 << (W - 1);
        int dv = ref_diff(xv, yv, bv);
        return (((xv >= h) != (yv >= h)) && ((dv >= h) != (xv >= h))) ? 1 : 0;
    endfunction

    task automatic run_op(input int xv, input int yv, input int bv, input bit noise);
        int ed = ref_diff(xv, yv, bv);
        int eb = ref_bout(xv, yv, bv);
        x = W'(xv); y = W'(yv); bin = bv[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_at_accept", busy, 1);
        chk("done_at_accept", done, 0);
        for (int i = 1; i < W; i++) begin
            if (noise) begin
                x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("diff_hold", diff, prev_diff);
            chk("bout_hold", bout, prev_bout);
        end
        if (noise) start = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 1);
        chk("diff", diff, ed);
        chk("bout", bout, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, ref_ovf(xv, yv, bv));
`endif
        if (noise) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cleared", done, 0);
        chk("busy_cleared", busy, 0);
        chk("diff_after", diff, ed);
        prev_diff = ed;
        prev_bout = eb;
    endtask

    initial begin
        int pulses, last, c;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(negedge clk) rst_n = 1'b1;

        run_op(9, 5, 0, 1'b0);
        run_op(3, 5, 0, 1'b0);
        run_op(0, 0, 1, 1'b0);
        run_op(8, 1, 0, 1'b1);
        run_op(7, 15, 0, 1'b1);
        run_op(15, 0, 1, 1'b0);

        // start held high: one result every W+2 cycles
        x = 4'd9; y = 4'd2; bin = 1'b0; start = 1'b1;
        pulses = 0; last = -1;
        for (c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                chk("held_diff", diff, ref_diff(9, 2, 0));
                if (last >= 0) chk("held_gap", c - last, W + 2);
                last = c;
                pulses++;
            end
        end
        start = 1'b0;
        chk("held_pulses", pulses, 5);
        for (int i = 0; i < 10 && busy; i++) @(posedge clk) #1;
        chk("held_idle", busy, 0);
        prev_diff = ref_diff(9, 2, 0);
        prev_bout = ref_bout(9, 2, 0);

        // reset two cycles after accept
        x = 4'd5; y = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", ovf, 0);
`endif
        pulses = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        @(negedge clk) rst_n = 1'b1;
        prev_diff = 0;
        prev_bout = 0;
        run_op(12, 4, 0, 1'b0);

        for (int k = 0; k < 25; k++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
